// File: rtl/pattern_sequencer.sv
// Double-banked p/n pattern sequencer for gate drivers: dead time on every pwm edge,
// then steps through the active bank's pattern, holding or wrapping at the end.
module pattern_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 3,
    parameter int unsigned DEAD_W = 3,
    parameter int unsigned DIV_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm,
    input  logic [DEAD_W-1:0] dead_cycles,
    input  logic [DIV_W-1:0]  step_div,
    input  logic              wrap_mode,
    input  logic              wr_en,
    input  logic              wr_phase,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              commit,
    output logic [WIDTH-1:0]  p_drive,
    output logic [WIDTH-1:0]  n_drive,
    output logic [STEP_W-1:0] step,
    output logic              dead,
    output logic              bank,
    output logic              commit_pending
);

    localparam int unsigned NSTEPS = 2 ** STEP_W;

    typedef enum logic [1:0] {
        S_DEAD,
        S_RUN,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [1:0][NSTEPS-1:0][WIDTH-1:0] p_tbl;
    logic [1:0][NSTEPS-1:0][WIDTH-1:0] n_tbl;

    logic              pwm_prev;
    logic              phase, phase_nxt;
    logic              pwm_edge;
    logic              load;
    logic [DEAD_W-1:0] dead_load;
    logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic [STEP_W-1:0] step_nxt;
    logic [WIDTH-1:0]  p_nxt, n_nxt;
    logic              dead_nxt, bank_nxt, pending_nxt;

    // A dead_cycles of 0 still gives one dead cycle.
    assign dead_load = (dead_cycles == '0) ? '0 : dead_cycles - DEAD_W'(1);
    assign pwm_edge  = (pwm != pwm_prev);

    always_ff @(posedge clk) begin
        if (reset) state <= S_DEAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        dead_cnt_nxt = dead_cnt;
        div_cnt_nxt  = div_cnt;
        step_nxt     = step;
        p_nxt        = p_drive;
        n_nxt        = n_drive;
        dead_nxt     = dead;
        bank_nxt     = bank;
        pending_nxt  = commit_pending | commit;
        load         = 1'b0;

        if (pwm_edge) begin
            // Any edge restarts dead time with the new phase; a pending swap lands here.
            state_nxt    = S_DEAD;
            phase_nxt    = pwm;
            dead_cnt_nxt = dead_load;
            dead_nxt     = 1'b1;
            p_nxt        = '1;
            n_nxt        = '0;
            if (pending_nxt) begin
                bank_nxt    = ~bank;
                pending_nxt = 1'b0;
            end
        end else begin
            case (state)
                S_DEAD: begin
                    if (dead_cnt == '0) begin
                        state_nxt   = S_RUN;
                        step_nxt    = '0;
                        div_cnt_nxt = '0;
                        dead_nxt    = 1'b0;
                        load        = 1'b1;
                    end else begin
                        dead_cnt_nxt = dead_cnt - DEAD_W'(1);
                    end
                end
                S_RUN: begin
                    if (div_cnt >= step_div) begin
                        div_cnt_nxt = '0;
                        if (step == STEP_W'(NSTEPS - 1)) begin
                            if (wrap_mode) begin
                                step_nxt = '0;
                                load     = 1'b1;
                            end else begin
                                state_nxt = S_HOLD;
                            end
                        end else begin
                            step_nxt = step + STEP_W'(1);
                            load     = 1'b1;
                        end
                    end else begin
                        div_cnt_nxt = div_cnt + DIV_W'(1);
                        load        = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_nxt = S_HOLD;
                end
                default: begin
                    state_nxt = S_DEAD;
                    dead_nxt  = 1'b1;
                    p_nxt     = '1;
                    n_nxt     = '0;
                end
            endcase
        end

        if (load) begin
            p_nxt = phase ? p_tbl[bank][step_nxt] : '1;
            n_nxt = phase ? '0 : n_tbl[bank][step_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_prev       <= pwm;
            phase          <= pwm;
            dead_cnt       <= dead_load;
            div_cnt        <= '0;
            step           <= '0;
            p_drive        <= '1;
            n_drive        <= '0;
            dead           <= 1'b1;
            bank           <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            pwm_prev       <= pwm;
            phase          <= phase_nxt;
            dead_cnt       <= dead_cnt_nxt;
            div_cnt        <= div_cnt_nxt;
            step           <= step_nxt;
            p_drive        <= p_nxt;
            n_drive        <= n_nxt;
            dead           <= dead_nxt;
            bank           <= bank_nxt;
            commit_pending <= pending_nxt;
        end
    end

    // Writes target the shadow bank as seen before any swap this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_tbl <= '1;
            n_tbl <= '0;
        end else if (wr_en) begin
            if (wr_phase) p_tbl[~bank][wr_addr] <= wr_data;
            else          n_tbl[~bank][wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: a timeline-based model predicts each cycle's
// outputs from time since the last pwm edge; a monitor compares them against the DUT.
module tb_pattern_sequencer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned DEAD_W = 3;
    localparam int unsigned DIV_W  = 4;
    localparam int NSTEPS = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pwm = 1'b0;
    logic [DEAD_W-1:0] dead_cycles = '0;
    logic [DIV_W-1:0]  step_div = '0;
    logic              wrap_mode = 1'b0;
    logic              wr_en = 1'b0;
    logic              wr_phase = 1'b0;
    logic [STEP_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              commit = 1'b0;
    logic [WIDTH-1:0]  p_drive, n_drive;
    logic [STEP_W-1:0] step;
    logic              dead, bank, commit_pending;

    pattern_sequencer #(
        .WIDTH(WIDTH), .STEP_W(STEP_W), .DEAD_W(DEAD_W), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .reset(reset), .pwm(pwm), .dead_cycles(dead_cycles),
        .step_div(step_div), .wrap_mode(wrap_mode), .wr_en(wr_en),
        .wr_phase(wr_phase), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .p_drive(p_drive), .n_drive(n_drive), .step(step),
        .dead(dead), .bank(bank), .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        logic [7:0] n;
        logic [2:0] stp;
        logic       dead;
        logic       bank;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] mp [2][NSTEPS];
    logic [7:0] mn [2][NSTEPS];
    logic m_bank, m_pend, m_phase, m_prev;
    int   m_t, m_d;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Model: outputs are a function of cycles elapsed since the last edge/reset.
    task automatic tick();
        exp_t e;
        int d, r, k, s;
        d = (dead_cycles == 0) ? 1 : int'(dead_cycles);
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NSTEPS; i++) begin
                    mp[b][i] = 8'hFF;
                    mn[b][i] = 8'h00;
                end
            m_bank = 1'b0; m_pend = 1'b0; m_phase = pwm; m_prev = pwm;
            m_t = 0; m_d = d;
        end else begin
            if (wr_en) begin
                if (wr_phase) mp[!m_bank][wr_addr] = wr_data;
                else          mn[!m_bank][wr_addr] = wr_data;
            end
            if (pwm != m_prev) begin
                m_phase = pwm; m_t = 0; m_d = d;
                if (m_pend || commit) begin
                    m_bank = !m_bank;
                    m_pend = 1'b0;
                end
            end else begin
                m_t++;
                if (commit) m_pend = 1'b1;
            end
            m_prev = pwm;
        end
        e.bank = m_bank;
        e.pend = m_pend;
        e.dead = (m_t < m_d);
        e.stp  = '0;
        e.p    = 8'hFF;
        e.n    = 8'h00;
        if (!e.dead) begin
            r = m_t - m_d;
            k = r / (int'(step_div) + 1);
            s = wrap_mode ? (k % NSTEPS) : ((k > NSTEPS - 1) ? NSTEPS - 1 : k);
            e.stp = 3'(s);
            if (m_phase) e.p = mp[m_bank][s];
            else         e.n = mn[m_bank][s];
        end
        exp_q.push_back(e);
        @(negedge clk);
        reset  = 1'b0;
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic toggle(input int dc, input int dv, input logic wm);
        pwm         = ~pwm;
        dead_cycles = 3'(dc);
        step_div    = 4'(dv);
        wrap_mode   = wm;
        tick();
    endtask

    task automatic write(input logic ph, input int a, input logic [7:0] dat);
        wr_en = 1'b1; wr_phase = ph; wr_addr = 3'(a); wr_data = dat;
    endtask

    // Monitor: one scoreboard entry per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dead", int'(dead), int'(e.dead));
                chk("p_drive", int'(p_drive), int'(e.p));
                chk("n_drive", int'(n_drive), int'(e.n));
                chk("bank", int'(bank), int'(e.bank));
                chk("commit_pending", int'(commit_pending), int'(e.pend));
                if (!e.dead) chk("step", int'(step), int'(e.stp));
                chk("shoot_through", int'(~p_drive & n_drive), 0);
            end
        end
    end

    initial begin
        // 1: reset, n phase, unit steps, hold at the end
        reset = 1'b1; pwm = 1'b0; dead_cycles = 3'd0; step_div = 4'd0; wrap_mode = 1'b0;
        tick();
        run(12);
        // 2: load shadow p table, commit, swap on rising edge with 3 dead cycles
        for (int i = 0; i < NSTEPS; i++) begin
            write(1'b1, i, 8'hF0 + 8'(i));
            tick();
        end
        commit = 1'b1;
        tick();
        toggle(3, 2, 1'b0);
        run(30);
        // 3: continuous wrap with unit steps while pwm stays high
        toggle(1, 0, 1'b1);
        run(4);
        toggle(1, 0, 1'b1);
        run(20);
        // 4: toggle at step 3, then again in the 2nd of 4 dead cycles
        toggle(1, 0, 1'b1);
        run(4);
        toggle(4, 0, 1'b1);
        toggle(4, 1, 1'b1);
        run(20);
        // 5: write to shadow in the same cycle as the committed swap
        commit = 1'b1;
        tick();
        run(2);
        write(pwm ? 1'b0 : 1'b1, 2, 8'hA5);
        toggle(1, 0, 1'b0);
        run(12);
        reset = 1'b1;
        tick();
        run(12);
        // Randomized traffic; config only changes together with an edge or reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) write($urandom_range(0, 1) == 1,
                                                  $urandom_range(0, NSTEPS - 1), 8'($urandom));
            if ($urandom_range(0, 3) == 0) write($urandom_range(0, 1) == 1,
                                                 $urandom_range(0, NSTEPS - 1), 8'($urandom));
            if ($urandom_range(0, 15) == 0) commit = 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                reset       = 1'b1;
                dead_cycles = 3'($urandom_range(0, 7));
                step_div    = 4'($urandom_range(0, 3));
                wrap_mode   = 1'($urandom_range(0, 1));
                tick();
            end else if ($urandom_range(0, 11) == 0) begin
                toggle($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else begin
                tick();
            end
        end
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
